sprite_blitter: RTL and testbench

Downstream consumer of the CPU's blit command outputs. It executes one blit command at a time: it fetches sprite bytes from program RAM through a dedicated read port and XORs them into the 128x64 monochrome framebuffer by read-modify-write. It also reports the CHIP-8 collision result and clears the framebuffer on request. The framebuffer read side for video scan-out is a separate RAM port outside this block.

---
 rtl/sprite_blitter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: executes one blit command at a time. SPRITE XORs sprite bytes
// from program RAM into the monochrome framebuffer using read-modify-write and
// reports the CHIP-8 collision flag. CLEAR zeroes all 1024 framebuffer bytes.
// Both RAM ports have a one-cycle registered read: data for an address presented
// in cycle N is valid in cycle N+1.
// Optional feature: define BLIT_WRAP_EN so that sprites wrap at the right and
// bottom edges. Without it, sprites are clipped at those edges.
module sprite_blitter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hires,
    input  logic        blit_enable,
    input  logic [2:0]  blit_op,
    input  logic [11:0] blit_src,
    input  logic [3:0]  blit_srcHeight,
    input  logic [6:0]  blit_destX,
    input  logic [5:0]  blit_destY,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic        src_en,
    output logic [11:0] src_addr,
    input  logic [7:0]  src_data,
    output logic        fb_en,
    output logic        fb_wr,
    output logic [9:0]  fb_addr,
    output logic [7:0]  fb_din,
    input  logic [7:0]  fb_dout
);

    localparam logic [2:0] BLIT_OP_SPRITE = 3'd1;
    localparam logic [2:0] BLIT_OP_CLEAR  = 3'd2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SRC_ADDR = 4'd1,
        ST_SRC_WAIT = 4'd2,
        ST_L_RD     = 4'd3,
        ST_L_WAIT   = 4'd4,
        ST_L_WR     = 4'd5,
        ST_R_RD     = 4'd6,
        ST_R_WAIT   = 4'd7,
        ST_R_WR     = 4'd8,
        ST_CLEAR    = 4'd9,
        ST_DONE     = 4'd10
    } state_t;

    state_t      state_r, state_s;

    // Latched command context
    logic        hires_r,  hires_s;
    logic [4:0]  height_r, height_s;   // 1..16 rows
    logic [6:0]  col_r,    col_s;      // start column, already mod W
    logic [5:0]  y_r,      y_s;        // start row, already mod H
    logic [4:0]  row_r,    row_s;      // current sprite row
    logic [7:0]  sprite_r, sprite_s;   // current sprite byte

    // Next values of the registered outputs
    logic        busy_s, done_s, collision_s, src_en_s, fb_en_s, fb_wr_s;
    logic [11:0] src_addr_s;
    logic [9:0]  fb_addr_s;
    logic [7:0]  fb_din_s;

    // Row/column geometry for the current row
    logic [15:0] shift_s;
    logic [7:0]  lmask_s, rmask_s;
    logic [3:0]  lcol_s, rcol_s;
    logic [5:0]  y_cur_s;
    logic        unaligned_s, right_ok_s, next_row_ok_s, last_row_s;
    logic        right_go_s, row_end_s;

    // One shift yields both masks: upper byte lands in the left byte column,
    // the bits shifted out fall into the right byte column.
    assign shift_s     = {sprite_r, 8'h00} >> col_r[2:0];
    assign lmask_s     = shift_s[15:8];
    assign rmask_s     = shift_s[7:0];
    assign lcol_s      = col_r[6:3];
    assign unaligned_s = (col_r[2:0] != 3'd0);
    assign last_row_s  = ((row_r + 5'd1) == height_r);

`ifdef BLIT_WRAP_EN
    logic [5:0] ysum_s;
    logic [3:0] rcol_sum_s;
    assign ysum_s        = y_r + {1'b0, row_r};
    assign y_cur_s       = hires_r ? ysum_s : {1'b0, ysum_s[4:0]};
    assign rcol_sum_s    = lcol_s + 4'd1;
    assign rcol_s        = hires_r ? rcol_sum_s : {1'b0, rcol_sum_s[2:0]};
    assign right_ok_s    = 1'b1;
    assign next_row_ok_s = 1'b1;
`else
    logic [6:0] ysum_s;
    logic [4:0] rcol_sum_s;
    assign ysum_s        = {1'b0, y_r} + {2'b00, row_r};
    assign y_cur_s       = ysum_s[5:0];
    assign rcol_sum_s    = {1'b0, lcol_s} + 5'd1;
    assign rcol_s        = rcol_sum_s[3:0];
    assign right_ok_s    = hires_r ? (rcol_sum_s < 5'd16) : (rcol_sum_s < 5'd8);
    // Rows only grow, so the first row past the bottom ends the sprite.
    assign next_row_ok_s = hires_r ? ((ysum_s + 7'd1) < 7'd64) : ((ysum_s + 7'd1) < 7'd32);
`endif

    assign right_go_s = unaligned_s && right_ok_s;
    assign row_end_s  = last_row_s || !next_row_ok_s;

    // Next-state and next-output logic for the command sequencer
    always_comb begin
        state_s     = state_r;
        hires_s     = hires_r;
        height_s    = height_r;
        col_s       = col_r;
        y_s         = y_r;
        row_s       = row_r;
        sprite_s    = sprite_r;
        collision_s = collision;
        src_addr_s  = src_addr;
        fb_addr_s   = fb_addr;
        fb_din_s    = fb_din;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        src_en_s    = 1'b0;
        fb_en_s     = 1'b0;
        fb_wr_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (blit_enable) begin
                    hires_s  = hires;
                    col_s    = hires ? blit_destX : {1'b0, blit_destX[5:0]};
                    y_s      = hires ? blit_destY : {1'b0, blit_destY[4:0]};
                    height_s = (blit_srcHeight == 4'd0) ? 5'd16 : {1'b0, blit_srcHeight};
                    row_s    = 5'd0;
                    case (blit_op)
                        BLIT_OP_SPRITE: begin
                            state_s     = ST_SRC_ADDR;
                            collision_s = 1'b0;
                            src_addr_s  = blit_src;
                        end
                        BLIT_OP_CLEAR: begin
                            state_s   = ST_CLEAR;
                            fb_addr_s = 10'd0;
                            fb_din_s  = 8'h00;
                        end
                        default: begin
                            state_s = ST_DONE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SRC_ADDR: begin
                state_s = ST_SRC_WAIT;
            end
            ST_SRC_WAIT: begin
                state_s   = ST_L_RD;
                sprite_s  = src_data;
                fb_addr_s = {y_cur_s, lcol_s};
            end
            ST_L_RD: begin
                state_s = ST_L_WAIT;
            end
            ST_L_WAIT: begin
                state_s     = ST_L_WR;
                fb_din_s    = fb_dout ^ lmask_s;
                collision_s = collision | (|(fb_dout & lmask_s));
            end
            ST_L_WR: begin
                if (right_go_s) begin
                    state_s   = ST_R_RD;
                    fb_addr_s = {y_cur_s, rcol_s};
                end else if (row_end_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s    = ST_SRC_ADDR;
                    row_s      = row_r + 5'd1;
                    src_addr_s = src_addr + 12'd1;
                end
            end
            ST_R_RD: begin
                state_s = ST_R_WAIT;
            end
            ST_R_WAIT: begin
                state_s     = ST_R_WR;
                fb_din_s    = fb_dout ^ rmask_s;
                collision_s = collision | (|(fb_dout & rmask_s));
            end
            ST_R_WR: begin
                if (row_end_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s    = ST_SRC_ADDR;
                    row_s      = row_r + 5'd1;
                    src_addr_s = src_addr + 12'd1;
                end
            end
            ST_CLEAR: begin
                if (fb_addr == 10'd1023) begin
                    state_s = ST_DONE;
                end else begin
                    fb_addr_s = fb_addr + 10'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Strobes follow the state being entered so they register cleanly
        busy_s   = (state_s != ST_IDLE);
        done_s   = (state_s == ST_DONE);
        src_en_s = (state_s == ST_SRC_ADDR);
        fb_wr_s  = (state_s == ST_L_WR) || (state_s == ST_R_WR) || (state_s == ST_CLEAR);
        fb_en_s  = fb_wr_s || (state_s == ST_L_RD) || (state_s == ST_R_RD);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command context and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hires_r   <= 1'b0;
            height_r  <= 5'd0;
            col_r     <= 7'd0;
            y_r       <= 6'd0;
            row_r     <= 5'd0;
            sprite_r  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            src_en    <= 1'b0;
            src_addr  <= 12'd0;
            fb_en     <= 1'b0;
            fb_wr     <= 1'b0;
            fb_addr   <= 10'd0;
            fb_din    <= 8'h00;
        end else begin
            hires_r   <= hires_s;
            height_r  <= height_s;
            col_r     <= col_s;
            y_r       <= y_s;
            row_r     <= row_s;
            sprite_r  <= sprite_s;
            busy      <= busy_s;
            done      <= done_s;
            collision <= collision_s;
            src_en    <= src_en_s;
            src_addr  <= src_addr_s;
            fb_en     <= fb_en_s;
            fb_wr     <= fb_wr_s;
            fb_addr   <= fb_addr_s;
            fb_din    <= fb_din_s;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter. Program RAM and framebuffer are bench
// models; a pixel-level reference framebuffer predicts each command's result,
// and expectations are queued at issue and checked when done is seen.
// Honours BLIT_WRAP_EN the same way as the design.
module tb_sprite_blitter;

`ifdef BLIT_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hires;
    logic        blit_enable;
    logic [2:0]  blit_op;
    logic [11:0] blit_src;
    logic [3:0]  blit_srcHeight;
    logic [6:0]  blit_destX;
    logic [5:0]  blit_destY;
    logic        busy, done, collision, src_en, fb_en, fb_wr;
    logic [11:0] src_addr;
    logic [7:0]  src_data;
    logic [9:0]  fb_addr;
    logic [7:0]  fb_din;
    logic [7:0]  fb_dout;

    logic [7:0]  pmem   [4096];
    logic [7:0]  fbmem  [1024];
    logic [7:0]  ref_fb [1024];
    bit          model_coll;

    int          wr_total = 0;
    int          nz_total = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    typedef struct {
        string tag;
        int    val;
    } sb_t;
    sb_t sb_q[$];

    sprite_blitter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hires          (hires),
        .blit_enable    (blit_enable),
        .blit_op        (blit_op),
        .blit_src       (blit_src),
        .blit_srcHeight (blit_srcHeight),
        .blit_destX     (blit_destX),
        .blit_destY     (blit_destY),
        .busy           (busy),
        .done           (done),
        .collision      (collision),
        .src_en         (src_en),
        .src_addr       (src_addr),
        .src_data       (src_data),
        .fb_en          (fb_en),
        .fb_wr          (fb_wr),
        .fb_addr        (fb_addr),
        .fb_din         (fb_din),
        .fb_dout        (fb_dout)
    );

    always #5 clk = ~clk;

    // Registered-read RAM models for program memory and framebuffer
    always @(posedge clk) begin
        if (src_en) src_data <= pmem[src_addr];
        if (fb_en) begin
            if (fb_wr) begin
                fbmem[fb_addr] <= fb_din;
                wr_total <= wr_total + 1;
                if (fb_din != 8'h00) nz_total <= nz_total + 1;
            end else begin
                fb_dout <= fbmem[fb_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // Pixel-level reference for one sprite; returns latency and write count
    task automatic model_sprite(input logic [11:0] src, input logic [3:0] hgt,
                                input logic [6:0] x, input logic [5:0] y, input bit hi,
                                output int lat, output int wr);
        int w, h, x0, y0, rows, yy, xx, a;
        logic [7:0] sb;
        w    = hi ? 128 : 64;
        h    = hi ? 64 : 32;
        x0   = int'(x) % w;
        y0   = int'(y) % h;
        rows = (hgt == 4'd0) ? 16 : int'(hgt);
        model_coll = 1'b0;
        lat = 1;
        wr  = 0;
        for (int r = 0; r < rows; r++) begin
            yy = y0 + r;
            if (yy >= h) begin
                if (WRAP) yy = yy - h;
                else break;
            end
            sb = pmem[(int'(src) + r) % 4096];
            for (int b = 0; b < 8; b++) begin
                if (sb[7-b]) begin
                    xx = x0 + b;
                    if (xx >= w) begin
                        if (WRAP) xx = xx - w;
                        else continue;
                    end
                    a = yy * 16 + xx / 8;
                    if (ref_fb[a][7 - (xx % 8)]) model_coll = 1'b1;
                    ref_fb[a][7 - (xx % 8)] = ~ref_fb[a][7 - (xx % 8)];
                end
            end
            lat += 5;
            wr  += 1;
            if ((x0 % 8) != 0 && (WRAP || (x0 / 8 + 1) < (w / 8))) begin
                lat += 3;
                wr  += 1;
            end
        end
    endtask

    // Issue one command, optionally pulse blit_enable again at cycle inj
    task automatic run_cmd(input logic [2:0] op, input logic [11:0] src, input logic [3:0] hgt,
                           input logic [6:0] x, input logic [5:0] y, input bit hi, input int inj);
        int lat, wr, w0, nz0, cnt, diff, got;
        logic d;
        sb_t e;
        if (op == 3'd1) begin
            model_sprite(src, hgt, x, y, hi, lat, wr);
        end else if (op == 3'd2) begin
            for (int a = 0; a < 1024; a++) ref_fb[a] = 8'h00;
            lat = 1025;
            wr  = 1024;
        end else begin
            lat = 1;
            wr  = 0;
        end
        sb_push("latency", lat);
        sb_push("collision", int'(model_coll));
        sb_push("writes", wr);
        sb_push("fb_diff", 0);
        w0  = wr_total;
        nz0 = nz_total;
        @(negedge clk);
        blit_op = op; blit_src = src; blit_srcHeight = hgt;
        blit_destX = x; blit_destY = y; hires = hi;
        blit_enable = 1'b1;
        @(posedge clk);
        cnt = 0;
        d   = 1'b0;
        while (!d && cnt < 3000) begin
            @(negedge clk);
            if (cnt == 0) check_eq("busy_after_accept", busy, 1);
            blit_enable = (inj != 0 && cnt == inj);
            if (inj != 0 && cnt == inj) blit_op = 3'd2;
            d = done;
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        blit_enable = 1'b0;
        check_eq("busy_after_done", busy, 0);
        check_eq("done_one_cycle", done, 0);
        if (op == 3'd2) check_eq("clear_nonzero_writes", nz_total - nz0, 0);
        diff = 0;
        for (int a = 0; a < 1024; a++) if (fbmem[a] !== ref_fb[a]) diff++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.tag)
                "latency":   got = cnt;
                "collision": got = int'(collision);
                "writes":    got = wr_total - w0;
                default:     got = diff;
            endcase
            check_eq(e.tag, got, e.val);
        end
    endtask

    initial begin
        rst_n = 1'b0; hires = 1'b0; blit_enable = 1'b0; blit_op = 3'd0;
        blit_src = 12'd0; blit_srcHeight = 4'd0; blit_destX = 7'd0; blit_destY = 6'd0;
        model_coll = 1'b0;
        for (int i = 0; i < 4096; i++) pmem[i] = 8'((i * 37) ^ (i >> 3));
        pmem[12'h300] = 8'hF0; pmem[12'h301] = 8'h90;
        pmem[12'h310] = 8'hFF;
        pmem[12'h320] = 8'hFF; pmem[12'h321] = 8'hFF;
        pmem[12'hFFF] = 8'hA5; pmem[12'h000] = 8'h3C;
        for (int i = 0; i < 1024; i++) ref_fb[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_collision", collision, 0);
        check_eq("rst_src_en", src_en, 0);
        check_eq("rst_fb_en", fb_en, 0);
        check_eq("rst_fb_wr", fb_wr, 0);
        check_eq("rst_src_addr", src_addr, 0);
        check_eq("rst_fb_addr", fb_addr, 0);
        check_eq("rst_fb_din", fb_din, 0);
        rst_n = 1'b1;

        run_cmd(3'd2, 12'h000, 4'd0, 7'd0, 6'd0, 1'b1, 0);

        run_cmd(3'd1, 12'h300, 4'd2, 7'd0, 6'd0, 1'b1, 0);
        check_eq("spr_fb000", fbmem[10'h000], 8'hF0);
        check_eq("spr_fb010", fbmem[10'h010], 8'h90);

        run_cmd(3'd1, 12'h300, 4'd2, 7'd0, 6'd0, 1'b1, 0);
        check_eq("rpt_fb000", fbmem[10'h000], 8'h00);
        check_eq("rpt_fb010", fbmem[10'h010], 8'h00);
        check_eq("rpt_collision", collision, 1);

        run_cmd(3'd1, 12'h310, 4'd1, 7'd5, 6'd3, 1'b1, 0);
        check_eq("x5_fb030", fbmem[10'h030], 8'h07);
        check_eq("x5_fb031", fbmem[10'h031], 8'hF8);

        run_cmd(3'd1, 12'h320, 4'd2, 7'd124, 6'd63, 1'b1, 0);
`ifdef BLIT_WRAP_EN
        check_eq("wrap_fb3ff", fbmem[10'h3FF], 8'h0F);
        check_eq("wrap_fb3f0", fbmem[10'h3F0], 8'hF0);
        check_eq("wrap_fb00f", fbmem[10'h00F], 8'h0F);
        check_eq("wrap_fb000", fbmem[10'h000], 8'hF0);
`else
        check_eq("clip_fb3ff", fbmem[10'h3FF], 8'h0F);
        check_eq("clip_fb3f0", fbmem[10'h3F0], 8'h00);
        check_eq("clip_fb00f", fbmem[10'h00F], 8'h00);
        check_eq("clip_fb000", fbmem[10'h000], 8'h00);
`endif

        run_cmd(3'd1, 12'h400, 4'd0, 7'd70, 6'd40, 1'b0, 0);
        run_cmd(3'd1, 12'h410, 4'd3, 7'd60, 6'd30, 1'b0, 0);
        run_cmd(3'd1, 12'hFFF, 4'd2, 7'd16, 6'd10, 1'b1, 0);
        run_cmd(3'd5, 12'h000, 4'd1, 7'd0, 6'd0, 1'b1, 0);
        run_cmd(3'd1, 12'h500, 4'd4, 7'd11, 6'd20, 1'b1, 4);

        // Reset in the middle of an unaligned sprite
        @(negedge clk);
        blit_op = 3'd1; blit_src = 12'h600; blit_srcHeight = 4'd4;
        blit_destX = 7'd3; blit_destY = 6'd5; hires = 1'b1;
        blit_enable = 1'b1;
        @(negedge clk);
        blit_enable = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_fb_wr", fb_wr, 0);
        check_eq("midrst_fb_en", fb_en, 0);
        check_eq("midrst_collision", collision, 0);
        rst_n = 1'b1;
        model_coll = 1'b0;
        run_cmd(3'd2, 12'h000, 4'd0, 7'd0, 6'd0, 1'b1, 0);
        run_cmd(3'd1, 12'h300, 4'd2, 7'd9, 6'd7, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
